alu_seq_engine: RTL
===================

// Module: alu_seq_engine
// PURPOSE
//  Sequential ALU core for ECE 351 exercise #2; the DUT that the result checker consumes.
//  - Captures switch operands and a test_selector_t opcode on a start strobe.
//  - Computes LEADING_ONES, NUM_ONES, ADD, SUB or MULT over multiple cycles.
//  - Drives the result onto led, with a busy/done handshake the stimulus bench waits on.
// PARAMETERS
//  BITS   16   operand/result width; even, >= 4. Upper half of sw = operand A, lower half = operand B.
// PORTS
//  clk     in   1                 system clock, all state on rising edge
//  reset   in   1                 asynchronous, active-high reset
//  start   in   1                 request; accepted only when busy==0
//  op      in   test_selector_t   operation, sampled with start
//  sw      in   BITS              operands, sampled with start
//  led     out  BITS              result register, holds last result
//  busy    out  1                 operation in progress
//  done    out  1                 one-cycle pulse, coincident with led update
// BEHAVIOUR
//  - Reset (async, any state): led=0, busy=0, done=0, FSM=IDLE. An in-flight operation is discarded.
//  - FSM: IDLE -> EXEC on start. EXEC -> FIN after N cycles. FIN -> IDLE after 1 cycle.
//    - FIN drives done=1.
//    - FIN->IDLE and a new start may coincide: start is sampled in FIN (busy==0 there).
//  - Capture: on the edge sampling start=1 while busy==0:
//    - register sw and op into internal operand regs; busy=1 from that edge.
//    - Later changes on sw/op do not affect the result.
//  - start while busy==1 is ignored (no queueing).
//  - EXEC length N:
//    - ADD/SUB: 1.
//    - LEADING_ONES/NUM_ONES: BITS (one bit scanned per cycle, LSB first).
//    - MULT: BITS/2 + 1.
//    - Undefined op: 1, result 0.
//  - On the edge leaving EXEC: led <= result, done=1, busy=0. Total latency start-edge -> done = N+1 edges.
//  - LEADING_ONES: index+1 of highest set bit of sw (all BITS), 0 if sw==0.
//    - Width $clog2(BITS)+1, zero-extended to BITS.
//  - NUM_ONES: popcount of sw, width $clog2(BITS)+1, zero-extended.
//  - ADD/SUB: A, B sign-extended to BITS, then A+B / A-B. Result is BITS wide, no overflow possible.
//  - MULT: signed A*B using the seq_mult sub-module.
//    - |A|, |B| are multiplied unsigned by shift-add, BITS/2 iterations.
//    - The final cycle negates the product if sign(A)!=sign(B).
//    - The result fits BITS exactly; -2^(h-1) * -2^(h-1) = +2^(BITS-2).
//  - led changes only on a FIN entry or on reset.
// CONFIGURATION
//  - ALU_SINGLE_CYCLE_EN defined: every op uses N=1, computed combinationally from the captured operands.
//    The handshake is unchanged: done is still 2 edges after start.
//  - Not defined: the iterative latencies above apply.
//  - Results are identical in both modes.
// STRUCTURE
//  - definitions_pkg (existing) supplies test_selector_t.
//  - Add to the package:
//    - alu_state_t enum {IDLE, EXEC, FIN}.
//    - localparam function to compute LO/NO result width from BITS.
//  - Sub-module seq_mult.
//    - Params HALF = BITS/2.
//    - Ports clk, reset, go, a, b (signed HALF), prod (signed BITS), valid.
//    - Used only when ALU_SINGLE_CYCLE_EN is undefined.
// TESTING (BITS=16, clk period 10; the bench waits for done, not a fixed delay)
//  - reset asserted mid-MULT (cycle 4 of EXEC) -> led=0, busy=0 immediately; next start runs normally.
//  - ADD, sw=16'h7F_81 (127 + -127) -> led=16'h0000, done exactly 2 edges after start.
//  - SUB, sw=16'h80_01 (-128 - 1) -> led=16'hFF7F (-129).
//  - MULT, sw=16'h80_80 -> led=16'h4000; sw=16'hFD_07 (-3*7) -> led=16'hFFEB; done 10 edges after start.
//  - LEADING_ONES, sw=16'h0400 -> led=16'd11; sw=0 -> led=0; NUM_ONES, sw=16'hFFFF -> led=16'd16; done after 17 edges.
//  - start re-pulsed with new op while busy -> ignored, result of first op; start in FIN cycle -> accepted.

Source files
------------

// File: rtl/definitions_pkg.sv
// Shared types for the ALU exercise: opcode selector, engine FSM states and sizing helpers.
package definitions_pkg;

   typedef enum logic [2:0] {
      LEADING_ONES = 3'd0,
      NUM_ONES     = 3'd1,
      ADD          = 3'd2,
      SUB          = 3'd3,
      MULT         = 3'd4
   } test_selector_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      FIN  = 2'd2
   } alu_state_t;

   // Width of the LEADING_ONES / NUM_ONES result before zero-extension.
   function automatic int unsigned cnt_res_width(input int unsigned bits);
      return $clog2(bits) + 1;
   endfunction

   // Number of EXEC cycles each operation takes in the iterative build.
   function automatic int unsigned exec_len(input test_selector_t op, input int unsigned bits);
      case (op)
         LEADING_ONES, NUM_ONES: return bits;
         MULT:                   return bits / 2 + 1;
         default:                return 1;
      endcase
   endfunction

endpackage

// File: rtl/alu_seq_engine_if.sv
// Start/operand request and result/handshake bundle between stimulus and the ALU engine.
interface alu_seq_engine_if #(
   parameter int unsigned BITS = 16
);
   logic                           start;
   definitions_pkg::test_selector_t op;
   logic [BITS-1:0]                sw;
   logic [BITS-1:0]                led;
   logic                           busy;
   logic                           done;

   modport master (output start, op, sw, input led, busy, done);
   modport slave  (input start, op, sw, output led, busy, done);
endinterface

// File: rtl/alu_seq_engine_mult.sv
// seq_mult: signed HALF x HALF multiplier, shift-add on magnitudes, sign applied in the final cycle.
module seq_mult #(
   parameter int unsigned HALF = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     go,
   input  logic signed [HALF-1:0]   a,
   input  logic signed [HALF-1:0]   b,
   output logic signed [2*HALF-1:0] prod,
   output logic                     valid
);
   localparam int unsigned PW = 2 * HALF;
   localparam int unsigned CW = $clog2(HALF + 1);

   logic [HALF-1:0] w_abs_a;
   logic [HALF-1:0] w_abs_b;
   logic [PW-1:0]   r_mcand;
   logic [PW-1:0]   r_acc;
   logic [HALF-1:0] r_mplier;
   logic [CW-1:0]   r_cnt;
   logic            r_neg;
   logic            r_run;

   // Most-negative input maps to 2^(HALF-1), which still fits unsigned HALF bits.
   assign w_abs_a = a[HALF-1] ? HALF'(-a) : HALF'(a);
   assign w_abs_b = b[HALF-1] ? HALF'(-b) : HALF'(b);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_run    <= 1'b0;
      end else if (go) begin
         r_mcand  <= PW'(w_abs_a);
         r_mplier <= w_abs_b;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= a[HALF-1] ^ b[HALF-1];
         r_run    <= 1'b1;
      end else if (r_run && (r_cnt != CW'(HALF))) begin
         if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
         end
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
      end
   end

   // Final cycle: magnitude product is complete, sign correction is applied here.
   assign valid = r_run && (r_cnt == CW'(HALF));
   assign prod  = r_neg ? PW'(-r_acc) : r_acc;

endmodule

// File: rtl/alu_seq_engine.sv
// Sequential ALU engine: captures operands on start, runs LEADING_ONES/NUM_ONES/ADD/SUB/MULT, reports via busy/done.
// ALU_SINGLE_CYCLE_EN: when defined every op finishes after one EXEC cycle using combinational datapaths.
module alu_seq_engine
   import definitions_pkg::*;
#(
   parameter int unsigned BITS = 16
) (
   input  logic           clk,
   input  logic           reset,
   alu_seq_engine_if.slave bus
);
   localparam int unsigned HALF = BITS / 2;
   localparam int unsigned CW   = $clog2(BITS);
   localparam int unsigned RW   = cnt_res_width(BITS);

   alu_state_t     r_state;
   test_selector_t r_op;
   logic [BITS-1:0] r_sw;
   logic [BITS-1:0] r_led;
   logic            r_busy;
   logic            r_done;
   logic [CW-1:0]   r_cyc;

   logic            w_accept;
   logic [CW-1:0]   w_last;
   logic [BITS-1:0] w_a_ext;
   logic [BITS-1:0] w_b_ext;
   logic [BITS-1:0] w_result;

   assign w_accept = bus.start && !r_busy;
   assign w_a_ext  = {{HALF{r_sw[BITS-1]}}, r_sw[BITS-1:HALF]};
   assign w_b_ext  = {{HALF{r_sw[HALF-1]}}, r_sw[HALF-1:0]};

`ifdef ALU_SINGLE_CYCLE_EN
   logic [RW-1:0] w_lo;
   logic [RW-1:0] w_no;

   assign w_last = '0;

   // Whole-word scan: highest set bit index+1 and population count.
   always_comb begin
      w_lo = '0;
      w_no = '0;
      for (int i = 0; i < int'(BITS); i++) begin
         if (r_sw[i]) begin
            w_lo = RW'(i + 1);
         end
         w_no = w_no + RW'(r_sw[i]);
      end
   end

   always_comb begin
      w_result = '0;
      case (r_op)
         LEADING_ONES: w_result = BITS'(w_lo);
         NUM_ONES:     w_result = BITS'(w_no);
         ADD:          w_result = w_a_ext + w_b_ext;
         SUB:          w_result = w_a_ext - w_b_ext;
         MULT:         w_result = w_a_ext * w_b_ext;
         default:      w_result = '0;
      endcase
   end
`else
   logic [BITS-1:0] r_scan;
   logic [RW-1:0]   r_lo;
   logic [RW-1:0]   r_no;
   logic [RW-1:0]   w_lo_next;
   logic [RW-1:0]   w_no_next;
   logic [BITS-1:0] w_prod;
   logic            w_mult_valid;

   assign w_last = CW'(exec_len(r_op, BITS) - 1);

   seq_mult #(.HALF(HALF)) u_mult (
      .clk   (clk),
      .reset (reset),
      .go    (w_accept),
      .a     (bus.sw[BITS-1:HALF]),
      .b     (bus.sw[HALF-1:0]),
      .prod  (w_prod),
      .valid (w_mult_valid)
   );

   // Bit r_cyc of the captured word sits in r_scan[0] during EXEC cycle r_cyc.
   always_comb begin
      w_lo_next = r_scan[0] ? (RW'(r_cyc) + RW'(1)) : r_lo;
      w_no_next = r_no + RW'(r_scan[0]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scan <= '0;
         r_lo   <= '0;
         r_no   <= '0;
      end else if (w_accept) begin
         r_scan <= bus.sw;
         r_lo   <= '0;
         r_no   <= '0;
      end else if (r_state == EXEC) begin
         r_scan <= r_scan >> 1;
         r_lo   <= w_lo_next;
         r_no   <= w_no_next;
      end
   end

   always_comb begin
      w_result = '0;
      case (r_op)
         LEADING_ONES: w_result = BITS'(w_lo_next);
         NUM_ONES:     w_result = BITS'(w_no_next);
         ADD:          w_result = w_a_ext + w_b_ext;
         SUB:          w_result = w_a_ext - w_b_ext;
         MULT:         w_result = w_mult_valid ? w_prod : '0;
         default:      w_result = '0;
      endcase
   end
`endif

   // Control FSM; start is honoured in IDLE and FIN, where busy is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_op    <= LEADING_ONES;
         r_sw    <= '0;
         r_led   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cyc   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, FIN: begin
               if (bus.start) begin
                  r_state <= EXEC;
                  r_busy  <= 1'b1;
                  r_op    <= bus.op;
                  r_sw    <= bus.sw;
                  r_cyc   <= '0;
               end else begin
                  r_state <= IDLE;
               end
            end
            EXEC: begin
               if (r_cyc == w_last) begin
                  r_state <= FIN;
                  r_led   <= w_result;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cyc <= r_cyc + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.led  = r_led;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule
